// File: rtl/alu_instruction_encoder.sv
// Encodes ALU instruction fields into 32-bit words, rejects illegal field sets,
// and buffers legal words in a small valid/ready FIFO with running counters.
module alu_instruction_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_alu_op,
    input  logic [1:0]       in_vec_perci,
    input  logic             in_alu_form,
    input  logic             in_const_c,
    input  logic [31:0]      in_constant,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [3:0]       in_c,
    input  logic [3:0]       in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instruction,
    output logic             err_illegal,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FC_W  = $clog2(DEPTH + 1);
    localparam logic [FC_W-1:0] FULL = FC_W'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [FC_W-1:0]  fifo_count;
    logic [31:0]      last_word;
    logic [31:0]      word;
    logic             illegal, push, reject, pop;

    always_comb begin
        word = '0;
        word[28]    = in_const_c;
        word[27:25] = in_alu_op;
        word[24]    = in_alu_form;
        word[23:22] = in_vec_perci;
        word[15:12] = in_a;
        if (in_const_c) begin
            word[11:0] = in_constant[11:0];
        end else begin
            word[11:8] = in_b;
            word[7:4]  = in_c;
            word[3:0]  = in_d;
        end
    end

    assign illegal = (in_const_c & (in_alu_form | (|in_constant[31:12])))
                   | (in_vec_perci == 2'b11);

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (fifo_count != FULL);
    assign out_valid = (fifo_count != '0);
    assign push      = in_valid & in_ready & ~illegal;
    assign reject    = in_valid & in_ready & illegal;
    assign pop       = out_valid & out_ready;

    // When empty, present the most recently popped word rather than stale storage.
    assign out_instruction = out_valid ? mem[rd_ptr] : last_word;

    // NOTE: the storage array carries no reset; validity is tracked by fifo_count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            last_word   <= '0;
            err_illegal <= 1'b0;
            err_count   <= '0;
            instr_count <= '0;
        end else begin
            err_illegal <= reject;
            if (push) begin
                wr_ptr      <= wr_ptr + PTR_W'(1);
                instr_count <= instr_count + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_word <= mem[rd_ptr];
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + FC_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - FC_W'(1);
            end
            if (reject && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_instruction_encoder.sv
// Self-checking bench for alu_instruction_encoder: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_alu_instruction_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam int ERR_W = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_alu_op;
    logic [1:0]       in_vec_perci;
    logic             in_alu_form;
    logic             in_const_c;
    logic [31:0]      in_constant;
    logic [3:0]       in_a, in_b, in_c, in_d;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instruction;
    logic             err_illegal;
    logic [ERR_W-1:0] err_count;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0]      exp_q[$];
    logic [31:0]      m_last;
    logic [CNT_W-1:0] m_instr;
    int               m_err;
    bit               m_err_pulse;
    bit               m_accepted;

    alu_instruction_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_vec_perci(in_vec_perci),
        .in_alu_form(in_alu_form), .in_const_c(in_const_c),
        .in_constant(in_constant),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction),
        .err_illegal(err_illegal), .err_count(err_count),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic bit ref_legal();
        if (in_vec_perci == 2'd3) return 1'b0;
        if (in_const_c && in_alu_form) return 1'b0;
        if (in_const_c && (in_constant >= 32'd4096)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_word();
        logic [31:0] w;
        w = 32'(in_const_c) * 32'h1000_0000 + 32'(in_alu_op) * 32'h0200_0000
          + 32'(in_alu_form) * 32'h0100_0000 + 32'(in_vec_perci) * 32'h0040_0000
          + 32'(in_a) * 32'h1000;
        if (in_const_c) w = w + (in_constant % 32'd4096);
        else            w = w + 32'(in_b) * 256 + 32'(in_c) * 16 + 32'(in_d);
        return w;
    endfunction

    function automatic logic [31:0] exp_out();
        return (exp_q.size() != 0) ? exp_q[0] : m_last;
    endfunction

    // Advance one clock from a negedge to the next, updating the model.
    task automatic tick();
        bit          pop_m, legal;
        logic [31:0] w;
        m_accepted = in_valid && (exp_q.size() < DEPTH);
        pop_m      = (exp_q.size() != 0) && out_ready;
        legal      = ref_legal();
        w          = ref_word();
        @(posedge clk);
        if (pop_m) m_last = exp_q.pop_front();
        if (m_accepted && legal) begin
            exp_q.push_back(w);
            m_instr = m_instr + 1'b1;
        end
        m_err_pulse = m_accepted && !legal;
        if (m_err_pulse && m_err < ERR_MAX) m_err++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last = '0;
        m_instr = '0;
        m_err = 0;
        m_err_pulse = 1'b0;
        m_accepted = 1'b0;
    endtask

    task automatic rand_fields(input bit legal);
        in_alu_op = 3'($urandom_range(0, 7));
        in_const_c = 1'($urandom_range(0, 1));
        in_a = 4'($urandom); in_b = 4'($urandom);
        in_c = 4'($urandom); in_d = 4'($urandom);
        if (legal) begin
            in_vec_perci = 2'($urandom_range(0, 2));
            in_alu_form = in_const_c ? 1'b0 : 1'($urandom_range(0, 1));
            in_constant = in_const_c ? 32'($urandom_range(0, 4095)) : $urandom;
        end else begin
            in_vec_perci = 2'($urandom_range(0, 3));
            in_alu_form = 1'($urandom_range(0, 1));
            in_constant = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 4095));
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b0;
        in_alu_op = '0; in_vec_perci = '0; in_alu_form = 1'b0; in_const_c = 1'b0;
        in_constant = '0; in_a = '0; in_b = '0; in_c = '0; in_d = '0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instruction !== 32'h0 ||
            err_illegal !== 1'b0 || err_count !== '0 || instr_count !== '0) begin
            errors++;
            $display("FAIL reset: out_valid=%b in_ready=%b out=%h err=%b err_count=%0d instr_count=%0d, required 0 1 0 0 0 0",
                     out_valid, in_ready, out_instruction, err_illegal, err_count, instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_encode();
        in_alu_op = 3'd0; in_vec_perci = 2'b10; in_alu_form = 1'b0; in_const_c = 1'b0;
        in_constant = '0; in_a = 4'd1; in_b = 4'd2; in_c = 4'd3; in_d = 4'd4;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_const_c = 1'b1; in_a = 4'd1; in_constant = 32'd2048;
        checks++;
        if (out_valid !== 1'b1 || out_instruction !== 32'h0080_1234) begin
            errors++;
            $display("FAIL basic_regs: out_valid=%b out=%h, required 1 00801234", out_valid, out_instruction);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_instruction !== 32'h1080_1800 || instr_count !== 16'd2) begin
            errors++;
            $display("FAIL basic_const: out_valid=%b out=%h instr_count=%0d, required 1 10801800 2",
                     out_valid, out_instruction, instr_count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_instruction !== 32'h1080_1800) begin
            errors++;
            $display("FAIL empty_hold: out_valid=%b out=%h, required 0 10801800", out_valid, out_instruction);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        in_const_c = 1'b1; in_alu_form = 1'b1; in_vec_perci = 2'b00;
        in_constant = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (err_illegal !== 1'b1 || err_count !== 8'd1 || out_valid !== 1'b0 ||
            in_ready !== 1'b1 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL illegal_pulse: err=%b err_count=%0d out_valid=%b in_ready=%b instr=%0d, required 1 1 0 1 0",
                     err_illegal, err_count, out_valid, in_ready, instr_count);
        end
        tick();
        checks++;
        if (err_illegal !== 1'b0 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL illegal_end: err=%b err_count=%0d, required 0 1", err_illegal, err_count);
        end
        // Wide constant and reserved vec_perci are each rejected on their own.
        in_const_c = 1'b1; in_alu_form = 1'b0; in_constant = 32'h0000_1000; in_valid = 1'b1;
        tick();
        in_const_c = 1'b0; in_vec_perci = 2'b11;
        tick();
        in_valid = 1'b0;
        checks++;
        if (err_illegal !== 1'b1 || err_count !== 8'd3 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_kinds: err=%b err_count=%0d out_valid=%b, required 1 3 0",
                     err_illegal, err_count, out_valid);
        end
    endtask

    task automatic test_err_saturate();
        do_reset();
        rand_fields(1'b1);
        in_vec_perci = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < ERR_MAX + 5; i++) tick();
        checks++;
        if (err_count !== 8'hFF || err_illegal !== 1'b1) begin
            errors++;
            $display("FAIL err_saturate: err_count=%0d err=%b, required 255 1", err_count, err_illegal);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (err_count !== 8'hFF || err_illegal !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_hold: err_count=%0d err=%b out_valid=%b, required 255 0 0",
                     err_count, err_illegal, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w[3];
        int got;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_fields(1'b1);
            w[i] = ref_word();
            in_valid = 1'b1;
            if (i < 2) tick();
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instruction !== w[0]) begin
                errors++;
                $display("FAIL full_hold[%0d]: in_ready=%b out_valid=%b out=%h, required 0 1 %h",
                         i, in_ready, out_valid, out_instruction, w[0]);
            end
            tick();
        end
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (out_instruction !== w[got]) begin
                    errors++;
                    $display("FAIL drain_order[%0d]: out=%h, required %h", got, out_instruction, w[got]);
                end
                got++;
            end
            tick();
            if (cyc == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_pop: in_ready=%b, required 1", in_ready);
                end
            end
            if (m_accepted) in_valid = 1'b0;
        end
        checks++;
        if (got != 3 || instr_count !== 16'd3) begin
            errors++;
            $display("FAIL drain_count: words=%0d instr_count=%0d, required 3 3", got, instr_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        int seen;
        do_reset();
        out_ready = 1'b1;
        seen = 0;
        prev = '0;
        for (int i = 0; i < 100; i++) begin
            rand_fields(1'b1);
            in_valid = 1'b1;
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_instruction !== prev) begin
                    errors++;
                    $display("FAIL stream[%0d]: out_valid=%b in_ready=%b out=%h, required 1 1 %h",
                             i, out_valid, in_ready, out_instruction, prev);
                end else seen++;
            end
            prev = ref_word();
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_instruction !== prev) begin
            errors++;
            $display("FAIL stream_last: out_valid=%b out=%h, required 1 %h", out_valid, out_instruction, prev);
        end else seen++;
        tick();
        checks++;
        if (out_valid !== 1'b0 || instr_count !== 16'd100 || seen != 100) begin
            errors++;
            $display("FAIL stream_end: out_valid=%b instr_count=%0d words=%0d, required 0 100 100",
                     out_valid, instr_count, seen);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() != DEPTH) ||
                out_instruction !== exp_out() || err_illegal !== m_err_pulse ||
                err_count !== ERR_W'(m_err) || instr_count !== m_instr) begin
                errors++;
                $display("FAIL random[%0d]: v=%b r=%b out=%h err=%b ec=%0d ic=%0d, required %b %b %h %b %0d %0d",
                         i, out_valid, in_ready, out_instruction, err_illegal, err_count, instr_count,
                         exp_q.size() != 0, exp_q.size() != DEPTH, exp_out(), m_err_pulse, m_err, m_instr);
            end
            rand_fields($urandom_range(0, 9) < 7);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_fields(1'b1);
            in_valid = 1'b1;
            tick();
        end
        in_const_c = 1'b1; in_alu_form = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || err_illegal !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_full: in_ready=%b out_valid=%b err=%b, required 0 1 0",
                     in_ready, out_valid, err_illegal);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_count !== '0 ||
            err_count !== '0 || err_illegal !== 1'b0 || out_instruction !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b ic=%0d ec=%0d err=%b out=%h, required 0 1 0 0 0 0",
                     out_valid, in_ready, instr_count, err_count, err_illegal, out_instruction);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_count !== '0) begin
            errors++;
            $display("FAIL post_reset: out_valid=%b in_ready=%b ic=%0d, required 0 1 0",
                     out_valid, in_ready, instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_encode();
        test_illegal();
        test_err_saturate();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
